pwm_dac_driver: RTL and testbench
=================================

// Module: pwm_dac_driver
// PURPOSE
//  Downstream stage of the sine generator: consumes its 8-bit unsigned wave
//  sample and converts it to a 1-bit PWM stream for an external RC-filter DAC.
//  Also produces the carrier count and the end-of-period strobe.
//  These are fed back as the generator's cnt_val / cnt_cout, so one sample
//  is played per PWM period.
// PARAMETERS
//  WIDTH     8  sample / carrier-counter width; period = 2^WIDTH-1 ticks
//  PRESCALE  1  clk cycles per carrier tick (>=1); 1 = tick every clk
// PORTS
//  clk       in   1      system clock, rising edge
//  rst       in   1      asynchronous, active-low reset (0 = reset)
//  en        in   1      run request, level sensitive
//  wave      in   WIDTH  unsigned duty sample from sine generator
//  pwm_out   out  1      registered PWM output
//  cnt_val   out  WIDTH  carrier counter, 0..2^WIDTH-2
//  cnt_cout  out  1      1-clk strobe on last clk of each period
//  busy      out  1      1 while state != IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; prescaler, cnt_val, duty_q all 0;
//    pwm_out=0, cnt_cout=0, busy=0. Reset mid-period aborts immediately.
//  tick: prescaler counts 0..PRESCALE-1; tick=1 when it equals PRESCALE-1.
//    Prescaler is held at 0 in IDLE.
//  FSM, 3 states:
//    IDLE: en=1 -> RUN next edge. On that edge: duty_q<=wave, cnt_val<=0,
//      prescaler<=0.
//    RUN: on tick, cnt_val increments.
//      At cnt_val==2^WIDTH-2 and tick, it wraps to 0, and duty_q<=wave.
//      duty_q is loaded only at period start; wave changes mid-period are
//      ignored. en=0 -> DRAIN (no other change).
//    DRAIN: counts as RUN. en=1 -> RUN with no restart or glitch.
//      At the wrap edge -> IDLE: cnt_val<=0 and duty_q is not reloaded.
//  cnt_cout = (state!=IDLE) && tick && cnt_val==2^WIDTH-2 (combinational
//    from registers).
//    It is asserted exactly once per period, including the final DRAIN period.
//  pwm_out(t+1) = (state(t)!=IDLE) && (cnt_val(t) < duty_q(t)).
//    Latency is one clk behind cnt_val.
//    High for duty_q*PRESCALE clks per period of (2^WIDTH-1)*PRESCALE clks.
//  Boundaries:
//    duty 0 -> pwm_out constantly 0.
//    duty 2^WIDTH-1 -> constantly 1 while running (100%).
//    en toggled 1->0->1 inside one period -> no effect on output.
//    en=1 for a single clk in IDLE -> exactly one full period, then IDLE.
//  Arithmetic is unsigned throughout; no saturation needed (compare only).
// STRUCTURE
//  Shared include dac_defs.vh: state encodings ST_IDLE=2'd0, ST_RUN=2'd1,
//    ST_DRAIN=2'd2, and the default WIDTH.
//  Sub-module tick_gen #(PRESCALE): prescaler counter with clear input and
//    tick output.
//  Top holds the FSM, carrier counter, duty_q and pwm_out register.
// TESTING
//  1 WIDTH=8, PRESCALE=1, wave=64, en=1 -> pwm_out high 64 clks then low
//    191 clks; cnt_cout pulses every 255 clks.
//  2 wave=0, then wave=255 in the next period -> 255 clks low, then
//    255 clks high; no glitch at the wrap.
//  3 wave changes 64->200 mid-period -> current period stays at 64;
//    the next period is 200 high.
//  4 en 1->0 at cnt_val=100 -> period completes, cnt_cout fires once,
//    busy drops the next clk, pwm_out=0.
//    Variant: en re-raised at cnt_val=150 -> continuous run.
//  5 PRESCALE=4, wave=10 -> 40 clks high per 1020-clk period;
//    cnt_cout width is 1 clk.
//  6 rst=0 asserted at cnt_val=30 with pwm_out=1 -> all outputs 0
//    asynchronously; with en=1 after release, a full new period starts
//    from cnt_val=0.

Source files
------------

// File: rtl/pwm_dac_driver_pkg.sv
// Shared definitions for the PWM DAC driver: FSM state encodings, default
// sample width and a helper for the last carrier count of a period.
`timescale 1ns/1ps

package pwm_dac_driver_pkg;

    localparam int unsigned DAC_WIDTH_DEF    = 8;
    localparam int unsigned DAC_PRESCALE_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } dac_state_e;

    // Last carrier value of a period; the carrier runs 0..2^width-2.
    function automatic int unsigned carrier_last(input int unsigned width);
        return (32'd1 << width) - 32'd2;
    endfunction

endpackage : pwm_dac_driver_pkg

// File: rtl/pwm_dac_driver_if.sv
// Sample/PWM bus between the sine generator and the PWM DAC driver.
//   en        run request from the generator
//   wave      unsigned duty sample from the generator
//   pwm_out   registered PWM bit towards the RC filter
//   cnt_val   carrier count, fed back to the generator
//   cnt_cout  end-of-period strobe, fed back to the generator
//   busy      driver is not idle
`timescale 1ns/1ps

interface pwm_dac_driver_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] wave;
    logic             pwm_out;
    logic [WIDTH-1:0] cnt_val;
    logic             cnt_cout;
    logic             busy;

    // Generator side: drives the request and sample, observes the carrier.
    modport master (
        output en,
        output wave,
        input  pwm_out,
        input  cnt_val,
        input  cnt_cout,
        input  busy
    );

    // Driver side.
    modport slave (
        input  en,
        input  wave,
        output pwm_out,
        output cnt_val,
        output cnt_cout,
        output busy
    );
endinterface : pwm_dac_driver_if

// File: rtl/pwm_dac_driver_tick_gen.sv
// Carrier prescaler: counts 0..PRESCALE-1 and flags the last count as tick.
//   clk    system clock
//   rst    asynchronous active-low reset
//   clr    hold the prescaler at 0 (driver idle)
//   tick   one-clk carrier tick, combinational from the count register
`timescale 1ns/1ps

module tick_gen #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;

    // Prescaler counter, cleared while idle and on each tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
        end else if (clr || (pre_cnt == PRE_LAST)) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    assign tick = (pre_cnt == PRE_LAST);

endmodule : tick_gen

// File: rtl/pwm_dac_driver.sv
// PWM DAC driver: turns the sine generator's unsigned sample into a 1-bit PWM
// stream, playing one sample per carrier period of (2^WIDTH-1) ticks.
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   slave side of pwm_dac_driver_if (en, wave in; pwm_out, cnt_val,
//         cnt_cout, busy out)
`timescale 1ns/1ps

module pwm_dac_driver
    import pwm_dac_driver_pkg::*;
#(
    parameter int unsigned WIDTH    = DAC_WIDTH_DEF,
    parameter int unsigned PRESCALE = DAC_PRESCALE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    pwm_dac_driver_if.slave  bus
);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(carrier_last(WIDTH));

    dac_state_e       state;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] duty_q;
    logic             pwm_q;
    logic             busy_q;
    logic             tick;
    logic             wrap_c;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == ST_IDLE),
        .tick (tick)
    );

    assign wrap_c = tick && (cnt_q == CNT_LAST);

    // FSM, carrier counter, duty latch and PWM comparator register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            cnt_q  <= '0;
            duty_q <= '0;
            pwm_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            pwm_q <= (state != ST_IDLE) && (cnt_q < duty_q);
            case (state)
                ST_IDLE: begin
                    if (bus.en) begin
                        state  <= ST_RUN;
                        busy_q <= 1'b1;
                        duty_q <= bus.wave;
                        cnt_q  <= '0;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (wrap_c) begin
                        // Period boundary: reload the sample or stop.
                        cnt_q <= '0;
                        if (bus.en) begin
                            state  <= ST_RUN;
                            duty_q <= bus.wave;
                        end else begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        if (tick) begin
                            cnt_q <= cnt_q + WIDTH'(1);
                        end
                        state <= bus.en ? ST_RUN : ST_DRAIN;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    cnt_q  <= '0;
                end
            endcase
        end
    end

    assign bus.pwm_out  = pwm_q;
    assign bus.cnt_val  = cnt_q;
    assign bus.busy     = busy_q;
    assign bus.cnt_cout = (state != ST_IDLE) && wrap_c;

endmodule : pwm_dac_driver

// File: tb/tb_pwm_dac_driver.sv
// Directed bench for pwm_dac_driver: one instance at PRESCALE=1 and one at
// PRESCALE=4, sharing clock and reset.
`timescale 1ns/1ps

module tb_pwm_dac_driver;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    pwm_dac_driver_if #(.WIDTH(8)) bus_a ();
    pwm_dac_driver_if #(.WIDTH(8)) bus_b ();

    pwm_dac_driver #(.WIDTH(8), .PRESCALE(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    pwm_dac_driver #(.WIDTH(8), .PRESCALE(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reset both instances, then request a run on the selected one with
    // sample w. Returns at the negedge following the IDLE->RUN edge.
    task automatic start(input bit sel, input int w);
        @(negedge clk);
        rst      = 1'b0;
        bus_a.en = 1'b0;
        bus_b.en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        if (sel) begin
            bus_b.wave = 8'(w);
            bus_b.en   = 1'b1;
        end else begin
            bus_a.wave = 8'(w);
            bus_a.en   = 1'b1;
        end
        @(negedge clk);
    endtask

    // Sample n consecutive negedges; count pwm highs and strobes.
    task automatic run_window(input bit sel, input int n, output int highs,
                              output int couts, output int last_idx,
                              output int busy_all);
        highs    = 0;
        couts    = 0;
        last_idx = -1;
        busy_all = 1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sel ? bus_b.pwm_out : bus_a.pwm_out) highs++;
            if (sel ? bus_b.cnt_cout : bus_a.cnt_cout) begin
                couts++;
                last_idx = i;
            end
            if (!(sel ? bus_b.busy : bus_a.busy)) busy_all = 0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int h, c, li, ba, h2, c2, li2, ba2;
        bus_a.en   = 1'b0;
        bus_a.wave = '0;
        bus_b.en   = 1'b0;
        bus_b.wave = '0;

        // Reset state
        #3;
        check_val("rst_pwm",  int'(bus_a.pwm_out),  0);
        check_val("rst_cnt",  int'(bus_a.cnt_val),  0);
        check_val("rst_cout", int'(bus_a.cnt_cout), 0);
        check_val("rst_busy", int'(bus_a.busy),     0);

        // 1: duty 64, two full periods
        start(1'b0, 64);
        check_val("t1_busy0", int'(bus_a.busy),    1);
        check_val("t1_cnt0",  int'(bus_a.cnt_val), 0);
        check_val("t1_pwm0",  int'(bus_a.pwm_out), 0);
        run_window(1'b0, 255, h, c, li, ba);
        check_val("t1_hi_p1",   h,  64);
        check_val("t1_cout_p1", c,  1);
        check_val("t1_cidx_p1", li, 253);
        run_window(1'b0, 255, h, c, li, ba);
        check_val("t1_hi_p2",   h,  64);
        check_val("t1_cout_p2", c,  1);
        check_val("t1_cidx_p2", li, 253);
        check_val("t1_busy",    ba, 1);

        // 2: duty 0 then 255 across a wrap
        start(1'b0, 0);
        bus_a.wave = 8'd255;
        run_window(1'b0, 255, h, c, li, ba);
        check_val("t2_hi_zero", h, 0);
        run_window(1'b0, 255, h, c, li, ba);
        check_val("t2_hi_full", h, 255);
        check_val("t2_cout",    c, 1);

        // 3: sample change mid-period is deferred to the next period
        start(1'b0, 64);
        run_window(1'b0, 100, h, c, li, ba);
        bus_a.wave = 8'd200;
        run_window(1'b0, 155, h2, c2, li2, ba2);
        check_val("t3_hi_p1", h + h2, 64);
        run_window(1'b0, 255, h, c, li, ba);
        check_val("t3_hi_p2", h, 200);

        // 4: en dropped at cnt_val=100, period drains then stops
        start(1'b0, 64);
        run_window(1'b0, 100, h, c, li, ba);
        check_val("t4_cnt100", int'(bus_a.cnt_val), 100);
        bus_a.en = 1'b0;
        run_window(1'b0, 155, h2, c2, li2, ba2);
        check_val("t4_hi",     h + h2, 64);
        check_val("t4_cout",   c + c2, 1);
        check_val("t4_busy",   int'(bus_a.busy),    0);
        check_val("t4_cnt",    int'(bus_a.cnt_val), 0);
        run_window(1'b0, 20, h, c, li, ba);
        check_val("t4_idle_hi",   h, 0);
        check_val("t4_idle_cout", c, 0);

        // 4 variant: en re-raised at cnt_val=150, run continues
        start(1'b0, 64);
        run_window(1'b0, 100, h, c, li, ba);
        bus_a.en = 1'b0;
        run_window(1'b0, 50, h2, c2, li2, ba2);
        check_val("t4v_cnt150", int'(bus_a.cnt_val), 150);
        bus_a.en = 1'b1;
        run_window(1'b0, 105, h2, c2, li2, ba2);
        check_val("t4v_busy_a", ba2, 1);
        run_window(1'b0, 255, h, c, li, ba);
        check_val("t4v_hi_p2",  h,  64);
        check_val("t4v_busy_b", ba, 1);

        // Single-clk en in IDLE: exactly one period
        start(1'b0, 64);
        bus_a.en = 1'b0;
        run_window(1'b0, 255, h, c, li, ba);
        check_val("t1c_hi",   h, 64);
        check_val("t1c_cout", c, 1);
        check_val("t1c_busy", int'(bus_a.busy), 0);

        // 6: async reset at cnt_val=30 with pwm high
        start(1'b0, 64);
        run_window(1'b0, 30, h, c, li, ba);
        check_val("t6_cnt30", int'(bus_a.cnt_val), 30);
        check_val("t6_pwm1",  int'(bus_a.pwm_out), 1);
        #2;
        rst = 1'b0;
        #1;
        check_val("t6_rst_pwm",  int'(bus_a.pwm_out), 0);
        check_val("t6_rst_cnt",  int'(bus_a.cnt_val), 0);
        check_val("t6_rst_busy", int'(bus_a.busy),    0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("t6_busy", int'(bus_a.busy),    1);
        check_val("t6_cnt0", int'(bus_a.cnt_val), 0);
        run_window(1'b0, 255, h, c, li, ba);
        check_val("t6_hi",   h, 64);
        check_val("t6_cout", c, 1);

        // 5: PRESCALE=4, duty 10 -> 40 clks high per 1020-clk period
        start(1'b1, 10);
        run_window(1'b1, 1020, h, c, li, ba);
        check_val("t5_hi_p1",   h,  40);
        check_val("t5_cout_p1", c,  1);
        check_val("t5_cidx_p1", li, 1018);
        run_window(1'b1, 1020, h, c, li, ba);
        check_val("t5_hi_p2",   h, 40);
        check_val("t5_cout_p2", c, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_pwm_dac_driver
